// File: rtl/fp_mult_arbiter.sv
// Round-robin arbiter sharing one fixed-latency FP32 multiplier among NUM_REQ requesters.
// Define FP_MULT_ARB_PERF_EN to add the issue/contention performance counters.
module fp_mult_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MULT_LAT = 5
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [DATA_W-1:0]         mult_in_data,
  output logic [DATA_W-1:0]         mult_mult,
  input  logic [DATA_W-1:0]         mult_out_data,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_data
`ifdef FP_MULT_ARB_PERF_EN
  ,
  input  logic                      perf_clr,
  output logic [31:0]               perf_issue_cnt,
  output logic [31:0]               perf_contend_cnt
`endif
);

  localparam int unsigned IdW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IdW-1:0]               rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]           grant;
  logic [IdW-1:0]               grant_id;
  logic                         transfer;
  logic [DATA_W-1:0]            in_data_q, in_data_d;
  logic [DATA_W-1:0]            mult_q, mult_d;
  // Stage 0 is the issue-stage tag; stages 1..MULT_LAT track the multiplier pipe.
  logic [MULT_LAT:0]            tag_vld_q, tag_vld_d;
  logic [MULT_LAT:0][IdW-1:0]   tag_id_q, tag_id_d;

  // Rotating priority search starting at rr_ptr_q; looks only at valid bits.
  always_comb begin
    logic [IdW:0]   sum;
    logic [IdW-1:0] idx;
    logic           found;
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    sum      = '0;
    idx      = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      sum = {1'b0, rr_ptr_q} + (IdW+1)'(off);
      if (sum >= (IdW+1)'(NUM_REQ)) begin
        sum = sum - (IdW+1)'(NUM_REQ);
      end
      idx = sum[IdW-1:0];
      if (!found && req_valid[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = idx;
      end
    end
  end

  assign transfer  = |grant;
  assign req_ready = reset_n ? grant : '0;

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    in_data_d = '0;
    mult_d    = '0;
    if (transfer) begin
      rr_ptr_d = (grant_id == IdW'(NUM_REQ - 1)) ? '0 : grant_id + IdW'(1);
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        in_data_d = req_a[i*DATA_W +: DATA_W];
        mult_d    = req_b[i*DATA_W +: DATA_W];
      end
    end
    tag_vld_d = {tag_vld_q[MULT_LAT-1:0], transfer};
    tag_id_d  = {tag_id_q[MULT_LAT-1:0], grant_id};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q  <= '0;
      in_data_q <= '0;
      mult_q    <= '0;
      tag_vld_q <= '0;
      tag_id_q  <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      in_data_q <= in_data_d;
      mult_q    <= mult_d;
      tag_vld_q <= tag_vld_d;
      tag_id_q  <= tag_id_d;
    end
  end

  assign mult_in_data = in_data_q;
  assign mult_mult    = mult_q;

  always_comb begin
    resp_valid = '0;
    resp_data  = '0;
    if (tag_vld_q[MULT_LAT]) begin
      resp_valid[tag_id_q[MULT_LAT]] = 1'b1;
      resp_data                      = mult_out_data;
    end
  end

`ifdef FP_MULT_ARB_PERF_EN
  logic [31:0] issue_cnt_q, issue_cnt_d;
  logic [31:0] contend_cnt_q, contend_cnt_d;
  logic        contend;

  // Two or more bits set: clearing the lowest set bit leaves something.
  assign contend = |(req_valid & (req_valid - NUM_REQ'(1)));

  always_comb begin
    issue_cnt_d   = issue_cnt_q;
    contend_cnt_d = contend_cnt_q;
    if (perf_clr) begin
      issue_cnt_d   = '0;
      contend_cnt_d = '0;
    end else begin
      if (transfer && (issue_cnt_q != '1)) begin
        issue_cnt_d = issue_cnt_q + 32'd1;
      end
      if (contend && (contend_cnt_q != '1)) begin
        contend_cnt_d = contend_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      issue_cnt_q   <= '0;
      contend_cnt_q <= '0;
    end else begin
      issue_cnt_q   <= issue_cnt_d;
      contend_cnt_q <= contend_cnt_d;
    end
  end

  assign perf_issue_cnt   = issue_cnt_q;
  assign perf_contend_cnt = contend_cnt_q;
`endif

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Scoreboard bench for fp_mult_arbiter driving a behavioural 5-stage FP32 multiplier model.
module tb_fp_mult_arbiter;

  localparam int unsigned NumReq  = 4;
  localparam int unsigned DataW   = 32;
  localparam int unsigned MultLat = 5;
  localparam int          RespLat = 1 + MultLat;

  logic                     clk;
  logic                     reset_n;
  logic [NumReq-1:0]        req_valid;
  logic [NumReq-1:0]        req_ready;
  logic [NumReq*DataW-1:0]  req_a;
  logic [NumReq*DataW-1:0]  req_b;
  logic [DataW-1:0]         mult_in_data;
  logic [DataW-1:0]         mult_mult;
  logic [DataW-1:0]         mult_out_data;
  logic [NumReq-1:0]        resp_valid;
  logic [DataW-1:0]         resp_data;
`ifdef FP_MULT_ARB_PERF_EN
  logic                     perf_clr;
  logic [31:0]              perf_issue_cnt;
  logic [31:0]              perf_contend_cnt;
`endif

  logic [31:0] op_a [NumReq];
  logic [31:0] op_b [NumReq];
  logic [31:0] mpipe [MultLat];

  typedef struct {
    int unsigned id;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur_exp;
  logic        have_exp;
  int          cyc;
  int          s_cyc;
  int          checks;
  int          errors;
  logic [3:0]  rdy_s;
  logic [3:0]  rv_s;
  logic [31:0] rd_s;

  fp_mult_arbiter #(
    .NUM_REQ  (NumReq),
    .DATA_W   (DataW),
    .MULT_LAT (MultLat)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .mult_in_data  (mult_in_data),
    .mult_mult     (mult_mult),
    .mult_out_data (mult_out_data),
    .resp_valid    (resp_valid),
    .resp_data     (resp_data)
`ifdef FP_MULT_ARB_PERF_EN
    ,
    .perf_clr         (perf_clr),
    .perf_issue_cnt   (perf_issue_cnt),
    .perf_contend_cnt (perf_contend_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NumReq; i++) begin
      req_a[i*DataW +: DataW] = op_a[i];
      req_b[i*DataW +: DataW] = op_b[i];
    end
  end

  // Normal-number FP32 multiply, round to nearest even; zero exponent treated as zero.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [9:0]  e;
    logic [22:0] m;
    logic        g;
    logic        s;
    logic [31:0] r;
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {a[31] ^ b[31], 31'd0};
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
    if (p[47]) begin
      e = e + 10'd1;
      m = p[46:24];
      g = p[23];
      s = |p[22:0];
    end else begin
      m = p[45:23];
      g = p[22];
      s = |p[21:0];
    end
    r = {a[31] ^ b[31], e[7:0], m};
    if (g && (s || m[0])) r = r + 32'd1;
    return r;
  endfunction

  // Free-running multiplier model: no reset, no enable.
  always @(posedge clk) begin
    mpipe[0] <= fp_mul(mult_in_data, mult_mult);
    for (int i = 1; i < MultLat; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mult_out_data = mpipe[MultLat-1];

  function automatic int unsigned oh_to_id(input logic [3:0] g);
    int unsigned id;
    id = 0;
    for (int i = 0; i < NumReq; i++) if (g[i]) id = i;
    return id;
  endfunction

  // Apply valids for one cycle, sample outputs, push expected issue, pop on response.
  task automatic step(input logic [3:0] v, input logic [3:0] g);
    exp_t e;
    req_valid = v;
    #1;
    rdy_s = req_ready;
    rv_s  = resp_valid;
    rd_s  = resp_data;
    s_cyc = cyc;
    if (g != 4'd0) begin
      e.id   = oh_to_id(g);
      e.data = fp_mul(op_a[e.id], op_b[e.id]);
      e.cyc  = cyc;
      sb.push_back(e);
    end
    have_exp = 1'b0;
    if (rv_s != 4'd0 && sb.size() > 0) begin
      cur_exp  = sb.pop_front();
      have_exp = 1'b1;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    req_valid = '0;
    reset_n   = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    sb.delete();
    cyc++;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    req_valid = '0;
    for (int i = 0; i < NumReq; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    for (int i = 0; i < MultLat; i++) mpipe[i] = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks += 5;
    if (req_ready !== 4'd0) begin
      errors++;
      $display("FAIL reset_ready got=%b exp=0", req_ready);
    end
    if (resp_valid !== 4'd0) begin
      errors++;
      $display("FAIL reset_resp_valid got=%b exp=0", resp_valid);
    end
    if (resp_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_resp_data got=%h exp=0", resp_data);
    end
    if (mult_in_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_in_data got=%h exp=0", mult_in_data);
    end
    if (mult_mult !== 32'd0) begin
      errors++;
      $display("FAIL reset_mult got=%h exp=0", mult_mult);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_single_op();
    int nresp;
    do_reset();
    nresp   = 0;
    op_a[0] = 32'h44FA0000;
    op_b[0] = 32'h41A00000;
    for (int c = 0; c < 10; c++) begin
      logic [3:0] v;
      v = (c < 1) ? 4'b0001 : 4'b0000;
      step(v, v);
      checks++;
      if (rdy_s !== v) begin
        errors++;
        $display("FAIL single_grant cyc=%0d got=%b exp=%b", c, rdy_s, v);
      end
      if (rv_s != 4'd0) begin
        nresp++;
        checks++;
        if (!have_exp || rv_s !== 4'b0001 || rd_s !== 32'h471C4000 ||
            s_cyc - cur_exp.cyc != RespLat) begin
          errors++;
          $display("FAIL single_resp got valid=%b data=%h lat=%0d exp valid=0001 data=471c4000 lat=%0d",
                   rv_s, rd_s, s_cyc - cur_exp.cyc, RespLat);
        end
      end
    end
    checks++;
    if (nresp != 1 || sb.size() != 0) begin
      errors++;
      $display("FAIL single_count got=%0d pending=%0d exp=1 pending=0", nresp, sb.size());
    end
  endtask

  task automatic test_full_contention();
    int nresp;
    do_reset();
    nresp = 0;
    op_a[0] = 32'h3FC00000; op_b[0] = 32'h40000000;
    op_a[1] = 32'h40200000; op_b[1] = 32'hBFA00000;
    op_a[2] = 32'h40400000; op_b[2] = 32'h3F000000;
    op_a[3] = 32'hC0800000; op_b[3] = 32'h40400000;
`ifdef FP_MULT_ARB_PERF_EN
    perf_clr = 1'b0;
`endif
    for (int c = 0; c < 17; c++) begin
      logic [3:0] v;
      logic [3:0] g;
      v = (c < 8) ? 4'hF : 4'h0;
      g = (c < 8) ? 4'(1 << (c % 4)) : 4'h0;
      step(v, g);
      checks++;
      if (rdy_s !== g) begin
        errors++;
        $display("FAIL contend_grant cyc=%0d got=%b exp=%b", c, rdy_s, g);
      end
      if (rv_s != 4'd0) begin
        nresp++;
        checks++;
        if (!have_exp || rv_s !== 4'(1 << cur_exp.id) || rd_s !== cur_exp.data ||
            s_cyc - cur_exp.cyc != RespLat) begin
          errors++;
          $display("FAIL contend_resp cyc=%0d got valid=%b data=%h exp id=%0d data=%h lat=%0d",
                   c, rv_s, rd_s, cur_exp.id, cur_exp.data, s_cyc - cur_exp.cyc);
        end
      end
    end
    checks++;
    if (nresp != 8 || sb.size() != 0) begin
      errors++;
      $display("FAIL contend_count got=%0d pending=%0d exp=8 pending=0", nresp, sb.size());
    end
`ifdef FP_MULT_ARB_PERF_EN
    checks += 2;
    if (perf_issue_cnt !== 32'd8 || perf_contend_cnt !== 32'd8) begin
      errors++;
      $display("FAIL perf_count got issue=%0d contend=%0d exp 8 8",
               perf_issue_cnt, perf_contend_cnt);
    end
    perf_clr = 1'b1;
    step(4'hF, 4'h1);
    perf_clr = 1'b0;
    req_valid = '0;
    #1;
    if (perf_issue_cnt !== 32'd0 || perf_contend_cnt !== 32'd0) begin
      errors++;
      $display("FAIL perf_clear got issue=%0d contend=%0d exp 0 0",
               perf_issue_cnt, perf_contend_cnt);
    end
    @(negedge clk);
    cyc++;
    sb.delete();
`endif
  endtask

  task automatic test_fairness();
    int nresp;
    do_reset();
    nresp = 0;
    for (int c = 0; c < 16; c++) begin
      logic [3:0] v;
      logic [3:0] g;
      v = (c < 8) ? 4'b1010 : 4'b0000;
      g = (c < 8) ? ((c % 2 == 0) ? 4'b0010 : 4'b1000) : 4'b0000;
      step(v, g);
      checks++;
      if (rdy_s !== g) begin
        errors++;
        $display("FAIL rr_grant cyc=%0d got=%b exp=%b", c, rdy_s, g);
      end
      if (rv_s != 4'd0) begin
        nresp++;
        checks++;
        if (!have_exp || rv_s !== 4'(1 << cur_exp.id) || rd_s !== cur_exp.data ||
            s_cyc - cur_exp.cyc != RespLat) begin
          errors++;
          $display("FAIL rr_resp cyc=%0d got valid=%b data=%h exp id=%0d data=%h",
                   c, rv_s, rd_s, cur_exp.id, cur_exp.data);
        end
      end
    end
    checks++;
    if (nresp != 8 || sb.size() != 0) begin
      errors++;
      $display("FAIL rr_count got=%0d pending=%0d exp=8 pending=0", nresp, sb.size());
    end
  endtask

  task automatic test_back_to_back();
    int nresp;
    do_reset();
    nresp   = 0;
    op_b[2] = 32'h40400000;
    for (int c = 0; c < 18; c++) begin
      logic [3:0] v;
      v = (c < 10) ? 4'b0100 : 4'b0000;
      if (c < 10) op_a[2] = 32'h3F800000 + (32'(c) << 18);
      step(v, v);
      checks++;
      if (rdy_s !== v) begin
        errors++;
        $display("FAIL b2b_grant cyc=%0d got=%b exp=%b", c, rdy_s, v);
      end
      if (rv_s != 4'd0) begin
        nresp++;
        checks++;
        if (!have_exp || rv_s !== 4'b0100 || rd_s !== cur_exp.data ||
            s_cyc - cur_exp.cyc != RespLat) begin
          errors++;
          $display("FAIL b2b_resp cyc=%0d got valid=%b data=%h exp data=%h lat=%0d",
                   c, rv_s, rd_s, cur_exp.data, s_cyc - cur_exp.cyc);
        end
      end
    end
    checks++;
    if (nresp != 10 || sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_count got=%0d pending=%0d exp=10 pending=0", nresp, sb.size());
    end
  endtask

  task automatic test_reset_midflight();
    int nresp;
    do_reset();
    nresp   = 0;
    op_a[0] = 32'h40A00000; op_b[0] = 32'h40A00000;
    op_a[1] = 32'h41000000; op_b[1] = 32'h3E800000;
    op_a[2] = 32'h3F400000; op_b[2] = 32'h41200000;
    for (int c = 0; c < 3; c++) step(4'b0111, 4'(1 << c));
    step(4'b0000, 4'b0000);
    step(4'b0000, 4'b0000);
    reset_n = 1'b0;
    sb.delete();
    @(negedge clk);
    cyc++;
    reset_n = 1'b1;
    for (int c = 0; c < 14; c++) begin
      logic [3:0] v;
      logic [3:0] g;
      v = (c == 2) ? 4'b1010 : 4'b0000;
      g = (c == 2) ? 4'b0010 : 4'b0000;
      step(v, g);
      checks++;
      if (rdy_s !== g) begin
        errors++;
        $display("FAIL rst_grant cyc=%0d got=%b exp=%b", c, rdy_s, g);
      end
      if (rv_s != 4'd0) begin
        nresp++;
        checks++;
        if (!have_exp || rv_s !== 4'b0010 || rd_s !== cur_exp.data ||
            s_cyc - cur_exp.cyc != RespLat) begin
          errors++;
          $display("FAIL rst_resp cyc=%0d got valid=%b data=%h exp valid=0010 data=%h",
                   c, rv_s, rd_s, cur_exp.data);
        end
      end
    end
    checks++;
    if (nresp != 1 || sb.size() != 0) begin
      errors++;
      $display("FAIL rst_count got=%0d pending=%0d exp=1 pending=0", nresp, sb.size());
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    cyc      = 0;
    have_exp = 1'b0;
`ifdef FP_MULT_ARB_PERF_EN
    perf_clr = 1'b0;
`endif
    test_reset();
    test_single_op();
    test_full_contention();
    test_fairness();
    test_back_to_back();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
